// File: rtl/rr_beat_generator.sv
// rr_beat_generator: converts RR intervals to sample periods and emits a
// peak pulse train at that spacing. Optional macro: RR_BEAT_GEN_REJCNT_EN.
module rr_beat_generator #(
  parameter int FS          = 360,
  parameter int MIN_SAMPLES = 72,
  parameter int PULSE_LEN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] rr_in,
  input  logic        rr_in_valid,
  output logic        peak_out,
  output logic [15:0] period_samples,
  output logic [15:0] beat_count,
  output logic        running,
  output logic        rr_err,
  output logic [7:0]  rej_count
);

  localparam int PW = $clog2(PULSE_LEN + 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_RUN
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_q, period_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] beat_q, beat_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic        err_q, err_d;

  logic [3:0]  rr_int;
  logic [10:0] rr_frac;
  logic [20:0] frac_prod;
  logic [20:0] frac_rnd;
  logic [15:0] conv;
  logic        rr_bad;
  logic        reload;
  logic [15:0] per_new;

  // Fixed-point seconds to rounded sample count, plus acceptance test
  always_comb begin
    rr_int    = rr_in[14:11];
    rr_frac   = rr_in[10:0];
    frac_prod = 21'(rr_frac) * 21'(FS);
    frac_rnd  = frac_prod + 21'd1024;
    conv      = 16'(rr_int) * 16'(FS)
              + 16'(frac_rnd >> 11);
    rr_bad    = rr_in[15]
              | (conv < 16'(MIN_SAMPLES));
  end

  // Next-state: beat FSM, reload, pending stage
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    beat_d     = beat_q;
    pulse_d    = pulse_q;
    err_d      = 1'b0;
    reload     = 1'b0;
    per_new    = period_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        pulse_d = '0;
        if (enable &&
            (pend_vld_q || period_q != '0)) begin
          state_d = S_RUN;
          reload  = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pulse_d = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
          if (pulse_q != '0)
            pulse_d = pulse_q - PW'(1);
          if (cnt_q == 16'd1)
            reload = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (reload) begin
      if (pend_vld_q)
        per_new = pend_q;
      period_d   = per_new;
      pend_vld_d = 1'b0;
      cnt_d      = per_new;
      beat_d     = beat_q + 16'd1;
      pulse_d    = PW'(PULSE_LEN);
    end

    // New input lands after the reload has consumed the old pending value
    if (rr_in_valid) begin
      if (rr_bad) begin
        err_d = 1'b1;
      end else begin
        pend_d     = conv;
        pend_vld_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      beat_q     <= '0;
      pulse_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      beat_q     <= beat_d;
      pulse_q    <= pulse_d;
      err_q      <= err_d;
    end
  end

`ifdef RR_BEAT_GEN_REJCNT_EN
  logic [7:0] rej_q, rej_d;

  // Saturating count of rejected inputs
  always_comb begin
    rej_d = rej_q;
    if (err_d && rej_q != 8'hFF)
      rej_d = rej_q + 8'd1;
  end

  // Rejection counter register
  always_ff @(posedge clk) begin
    if (rst)
      rej_q <= '0;
    else
      rej_q <= rej_d;
  end

  assign rej_count = rej_q;
`else
  assign rej_count = '0;
`endif

  assign peak_out       = (pulse_q != '0);
  assign period_samples = period_q;
  assign beat_count     = beat_q;
  assign running        = (state_q == S_RUN);
  assign rr_err         = err_q;

endmodule

// File: tb/tb_rr_beat_generator.sv
// tb_rr_beat_generator: directed stimulus with a cycle-level
// reference model of beat timing and a per-cycle compare.
module tb_rr_beat_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] rr_in;
  logic        rr_in_valid;
  logic        peak_out;
  logic [15:0] period_samples;
  logic [15:0] beat_count;
  logic        running;
  logic        rr_err;
  logic [7:0]  rej_count;

  rr_beat_generator dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .rr_in          (rr_in),
    .rr_in_valid    (rr_in_valid),
    .peak_out       (peak_out),
    .period_samples (period_samples),
    .beat_count     (beat_count),
    .running        (running),
    .rr_err         (rr_err),
    .rej_count      (rej_count)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;
  int edges[$];
  bit prev_peak = 1'b0;

  // Reference model, expressed in absolute beat times
  bit m_run;
  int m_period, m_pend, m_beats;
  bit m_pv, m_err;
  int m_last, m_next, m_rej;

  function automatic int conv(logic [15:0] v);
    int ip, fp;
    ip = int'(v[14:11]);
    fp = int'(v[10:0]);
    return ip * 360
         + $rtoi($itor(fp) * 360.0 / 2048.0 + 0.5);
  endfunction

  task automatic check(string name, int act, int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    bit rl;
    int s;
    cyc++;
    rl = 1'b0;
    if (rst) begin
      m_run = 0; m_period = 0; m_pend = 0; m_pv = 0;
      m_beats = 0; m_err = 0; m_rej = 0;
      m_last = -1000; m_next = 0;
    end else begin
      m_err = 0;
      if (m_run && !enable)
        m_run = 0;
      else if (!m_run && enable && (m_pv || m_period != 0)) begin
        m_run = 1;
        rl = 1'b1;
      end else if (m_run && cyc == m_next)
        rl = 1'b1;
      if (rl) begin
        if (m_pv) begin
          m_period = m_pend;
          m_pv = 0;
        end
        m_beats = (m_beats + 1) & 16'hFFFF;
        m_last = cyc;
        m_next = cyc + m_period;
      end
      if (rr_in_valid) begin
        s = conv(rr_in);
        if (rr_in[15] || s < 72) begin
          m_err = 1;
          if (m_rej < 255) m_rej++;
        end else begin
          m_pend = s;
          m_pv = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("peak_out", int'(peak_out),
            int'(m_run && (cyc - m_last) < 1));
      check("running", int'(running), int'(m_run));
      check("period_samples", int'(period_samples), m_period);
      check("beat_count", int'(beat_count), m_beats);
      check("rr_err", int'(rr_err), int'(m_err));
`ifdef RR_BEAT_GEN_REJCNT_EN
      check("rej_count", int'(rej_count), m_rej);
`else
      check("rej_count", int'(rej_count), 0);
`endif
      if (peak_out && !prev_peak)
        edges.push_back(cyc);
      prev_peak = peak_out;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(logic [15:0] v);
    rr_in = v;
    rr_in_valid = 1'b1;
    tick(1);
    rr_in_valid = 1'b0;
  endtask

  task automatic wait_edges(int n, int budget);
    int t = 0;
    while (edges.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    if (edges.size() < n)
      check("edge_timeout", edges.size(), n);
  endtask

  initial begin
    int n0, k, last, r;
    rst = 1'b1;
    enable = 1'b1;
    rr_in = '0;
    rr_in_valid = 1'b0;
    tick(3);
    check("rst_period", int'(period_samples), 0);
    check("rst_beats", int'(beat_count), 0);
    check("rst_running", int'(running), 0);
    check("rst_peak", int'(peak_out), 0);
    check("rst_rej", int'(rej_count), 0);
    rst = 1'b0;
    tick(1000);
    check("idle_no_peak", edges.size(), 0);

    // 1.0 s interval
    n0 = cyc;
    k = edges.size();
    apply(16'h0800);
    wait_edges(k + 5, 2500);
    check("first_peak", edges[k] - n0, 2);
    for (int i = 1; i < 5; i++)
      check("gap_1s", edges[k+i] - edges[k+i-1], 360);
    check("period_1s", int'(period_samples), 360);
    check("beats_5", int'(beat_count), 5);

    // 0.8 s mid-beat update
    tick(100);
    k = edges.size();
    last = edges[k-1];
    apply(16'h0666);
    wait_edges(k + 3, 1500);
    check("gap_cur", edges[k] - last, 360);
    check("gap_08a", edges[k+1] - edges[k], 288);
    check("gap_08b", edges[k+2] - edges[k+1], 288);
    check("period_08", int'(period_samples), 288);

    // rejects
    apply(16'h8800);
    check("rej_sign_err", int'(rr_err), 1);
    check("rej_sign_per", int'(period_samples), 288);
    tick(1);
    check("err_clears", int'(rr_err), 0);
    apply(16'h0080);
    check("rej_short_err", int'(rr_err), 1);
    check("rej_short_per", int'(period_samples), 288);
`ifdef RR_BEAT_GEN_REJCNT_EN
    check("rej_count2", int'(rej_count), 2);
`else
    check("rej_count0", int'(rej_count), 0);
`endif

    // enable drop and resume
    apply(16'h0800);
    k = edges.size();
    wait_edges(k + 2, 1500);
    tick(50);
    enable = 1'b0;
    tick(1);
    check("drop_running", int'(running), 0);
    check("drop_peak", int'(peak_out), 0);
    tick(20);
    r = cyc;
    k = edges.size();
    enable = 1'b1;
    wait_edges(k + 2, 1500);
    check("resume_entry", edges[k] - r, 1);
    check("resume_gap", edges[k+1] - edges[k], 360);
    check("resume_per", int'(period_samples), 360);

    // back-to-back inputs, last wins
    tick(10);
    k = edges.size();
    apply(16'h0800);
    apply(16'h0A00);
    wait_edges(k + 2, 2000);
    check("b2b_cur", edges[k] - edges[k-1], 360);
    check("b2b_gap", edges[k+1] - edges[k], 450);
    check("b2b_per", int'(period_samples), 450);

    // reset mid-beat
    tick(100);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mrst_running", int'(running), 0);
    check("mrst_peak", int'(peak_out), 0);
    check("mrst_period", int'(period_samples), 0);
    check("mrst_beats", int'(beat_count), 0);
    k = edges.size();
    tick(600);
    check("mrst_no_pulse", edges.size(), k);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miss_cnt);
    $finish;
  end

endmodule
